// File: rtl/uart_buf_pkg.sv
// Shared types and constants for the UART frame buffer.
package uart_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_WAIT_TX = 2'd3
    } state_e;

    localparam logic MODE_REPLAY = 1'b0;
    localparam logic MODE_ECHO   = 1'b1;

    // A press is a debounced event whose level is low; releases are ignored.
    function automatic logic is_key_press(input logic key_flag, input logic key_state);
        return key_flag && !key_state;
    endfunction

endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
module frame_buf_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_frame_buf.sv
// UART byte buffer: stores received bytes and replays them on a key press
// (mode 0) or echoes them as they arrive (mode 1). Optional sticky overflow
// flag enabled by defining UART_FRAME_BUF_OVF_EN.
module uart_frame_buf
    import uart_buf_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic              key_flag,
    input  logic              key_state,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_done,
    output logic              send_en,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   level,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned LVL_W      = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   replay_cnt_q, replay_cnt_d;
    logic               mode_q, mode_d;
    logic               send_en_q, send_en_d;
    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               busy_q;
    logic               pop_c;
    logic               wr_en_c;
    logic [DATA_W-1:0]  ram_rd_data;

    // Bytes are accepted in every state; a full buffer drops them.
    assign wr_en_c = rx_done && (level_q != FULL_LEVEL);

    frame_buf_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_ptr_q),
        .wr_data (rx_data),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // Next-state, pointer and output computation.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        replay_cnt_d = replay_cnt_q;
        mode_d       = mode_q;
        send_en_d    = 1'b0;
        tx_data_d    = tx_data_q;
        pop_c        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mode == MODE_ECHO) begin
                    if (level_q != '0) begin
                        state_d = ST_FETCH;
                        mode_d  = MODE_ECHO;
                    end
                end else if (is_key_press(key_flag, key_state) && (level_q != '0)) begin
                    state_d      = ST_FETCH;
                    mode_d       = MODE_REPLAY;
                    replay_cnt_d = level_q;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d = ram_rd_data;
                send_en_d = 1'b1;
                pop_c     = 1'b1;
                state_d   = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (mode_q == MODE_REPLAY) begin
                        replay_cnt_d = replay_cnt_q - LVL_ONE;
                        state_d      = (replay_cnt_q != LVL_ONE) ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = (level_q != '0) ? ST_FETCH : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_en_c, pop_c})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            replay_cnt_q <= '0;
            mode_q       <= MODE_REPLAY;
            send_en_q    <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            replay_cnt_q <= replay_cnt_d;
            mode_q       <= mode_d;
            send_en_q    <= send_en_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

`ifdef UART_FRAME_BUF_OVF_EN
    logic overflow_q, overflow_d;
    logic replay_start_c;
    logic drop_c;

    assign replay_start_c = (state_q == ST_IDLE) && (state_d == ST_FETCH)
                          && (mode_d == MODE_REPLAY);
    assign drop_c         = rx_done && !wr_en_c;

    // A drop in the same cycle as a replay start still flags.
    always_comb begin
        overflow_d = overflow_q;
        if (replay_start_c) begin
            overflow_d = 1'b0;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign send_en = send_en_q;
    assign tx_data = tx_data_q;
    assign level   = level_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uart_frame_buf.sv
// Self-checking bench for uart_frame_buf (DEPTH=4) with an expected-byte scoreboard.
module tb_uart_frame_buf;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
`ifdef UART_FRAME_BUF_OVF_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mode;
    logic              key_flag;
    logic              key_state;
    logic              rx_done;
    logic [DATA_W-1:0] rx_data;
    logic              tx_done;
    logic              send_en;
    logic [DATA_W-1:0] tx_data;
    logic [ADDR_W:0]   level;
    logic              busy;
    logic              overflow;

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];

    uart_frame_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .key_flag  (key_flag),
        .key_state (key_state),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .tx_done   (tx_done),
        .send_en   (send_en),
        .tx_data   (tx_data),
        .level     (level),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_byte(input logic [DATA_W-1:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic press_key();
        key_flag  = 1'b1;
        key_state = 1'b0;
        tick();
        key_flag  = 1'b0;
        key_state = 1'b1;
    endtask

    task automatic wait_send(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (send_en) begin
                got = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic finish_tx();
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic count_sends(input int cycles, output int sends);
        sends = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (send_en) sends++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        n_vec++; if (send_en !== 1'b0) begin n_err++; $display("FAIL reset_send_en: got %b expected 0", send_en); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_replay();
        bit got;
        logic [DATA_W-1:0] exp;
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = 8'h41 + 8'(i);
            exp_q.push_back(exp);
            rx_byte(exp);
        end
        tick();
        n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL replay_level_pre: got %0d expected 3", level); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL replay_idle_busy: got %b expected 0", busy); end
        press_key();
        for (int k = 0; k < 3; k++) begin
            wait_send(20, got);
            n_vec++; if (!got) begin n_err++; $display("FAIL replay_send_en[%0d]: got none expected pulse", k); end
            exp = exp_q.pop_front();
            n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL replay_tx_data[%0d]: got %h expected %h", k, tx_data, exp); end
            n_vec++; if (level !== 3'(2 - k)) begin n_err++; $display("FAIL replay_level[%0d]: got %0d expected %0d", k, level, 2 - k); end
            tick();
            tick();
            n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL replay_hold[%0d]: got %h expected %h", k, tx_data, exp); end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL replay_busy_end: got %b expected 0", busy); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL replay_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_echo();
        logic [DATA_W-1:0] exp;
        mode = 1'b1;
        exp_q.push_back(8'h55);
        rx_byte(8'h55);
        tick();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL echo_busy: got %b expected 1", busy); end
        n_vec++; if (send_en !== 1'b0) begin n_err++; $display("FAIL echo_early0: got %b expected 0", send_en); end
        tick();
        n_vec++; if (send_en !== 1'b0) begin n_err++; $display("FAIL echo_early1: got %b expected 0", send_en); end
        tick();
        n_vec++; if (send_en !== 1'b1) begin n_err++; $display("FAIL echo_latency: got %b expected 1", send_en); end
        exp = exp_q.pop_front();
        n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL echo_tx_data: got %h expected %h", tx_data, exp); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL echo_level: got %0d expected 0", level); end
        finish_tx();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL echo_busy_end: got %b expected 0", busy); end
        mode = 1'b0;
    endtask

    task automatic test_overflow();
        bit got;
        int sends;
        logic [DATA_W-1:0] exp;
        mode = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            rx_byte(8'(i));
        end
        rx_byte(8'h99);
        n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d expected 4", level); end
        n_vec++; if (overflow !== EXP_OVF) begin n_err++; $display("FAIL ovf_flag: got %b expected %b", overflow, EXP_OVF); end
        press_key();
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            wait_send(20, got);
            n_vec++; if (!got) begin n_err++; $display("FAIL ovf_send_en[%0d]: got none expected pulse", k); end
            exp = exp_q.pop_front();
            n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL ovf_tx_data[%0d]: got %h expected %h", k, tx_data, exp); end
            finish_tx();
        end
        count_sends(20, sends);
        n_vec++; if (sends != 0) begin n_err++; $display("FAIL ovf_extra_send: got %0d expected 0", sends); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL ovf_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_rx_during_replay();
        bit got;
        int sends;
        logic [DATA_W-1:0] exp;
        mode = 1'b0;
        exp_q.push_back(8'h10);
        rx_byte(8'h10);
        exp_q.push_back(8'h20);
        rx_byte(8'h20);
        press_key();
        for (int k = 0; k < 2; k++) begin
            wait_send(20, got);
            n_vec++; if (!got) begin n_err++; $display("FAIL mid_send_en[%0d]: got none expected pulse", k); end
            exp = exp_q.pop_front();
            n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL mid_tx_data[%0d]: got %h expected %h", k, tx_data, exp); end
            if (k == 0) begin
                rx_byte(8'h77);
                press_key();
            end
            finish_tx();
        end
        count_sends(20, sends);
        n_vec++; if (sends != 0) begin n_err++; $display("FAIL mid_extra_send: got %0d expected 0", sends); end
        n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL mid_level: got %0d expected 1", level); end
        exp_q.push_back(8'h77);
        press_key();
        wait_send(20, got);
        n_vec++; if (!got) begin n_err++; $display("FAIL mid_second_send: got none expected pulse"); end
        exp = exp_q.pop_front();
        n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL mid_second_data: got %h expected %h", tx_data, exp); end
        finish_tx();
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_level_end: got %0d expected 0", level); end
    endtask

    task automatic test_reset_mid_tx();
        bit got;
        int sends;
        mode = 1'b0;
        rx_byte(8'hA1);
        rx_byte(8'hA2);
        press_key();
        wait_send(20, got);
        n_vec++; if (!got) begin n_err++; $display("FAIL rst_pre_send: got none expected pulse"); end
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        n_vec++; if (send_en !== 1'b0) begin n_err++; $display("FAIL rst_mid_send_en: got %b expected 0", send_en); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_tx_data: got %h expected 00", tx_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_mid_level: got %0d expected 0", level); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_mid_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        count_sends(20, sends);
        n_vec++; if (sends != 0) begin n_err++; $display("FAIL rst_stale_tx_done: got %0d sends expected 0", sends); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_wrap();
        bit got;
        int val;
        int n;
        logic [DATA_W-1:0] exp;
        mode = 1'b1;
        val  = 0;
        while (val < 10) begin
            n = (10 - val < 4) ? 10 - val : 4;
            for (int j = 0; j < n; j++) begin
                exp_q.push_back(8'(val));
                rx_byte(8'(val));
                val++;
            end
            for (int j = 0; j < n; j++) begin
                wait_send(20, got);
                n_vec++; if (!got) begin n_err++; $display("FAIL wrap_send_en[%0d]: got none expected pulse", val - n + j); end
                exp = exp_q.pop_front();
                n_vec++; if (tx_data !== exp) begin n_err++; $display("FAIL wrap_tx_data: got %h expected %h", tx_data, exp); end
                n_vec++; if (level !== 3'(exp_q.size())) begin n_err++; $display("FAIL wrap_level: got %0d expected %0d", level, exp_q.size()); end
                finish_tx();
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wrap_busy_end: got %b expected 0", busy); end
        mode = 1'b0;
    endtask

    initial begin
        mode      = 1'b0;
        key_flag  = 1'b0;
        key_state = 1'b1;
        rx_done   = 1'b0;
        rx_data   = '0;
        tx_done   = 1'b0;
        test_reset();
        test_replay();
        test_echo();
        test_overflow();
        test_rx_during_replay();
        test_reset_mid_tx();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_frame_buf.md
UART_FRAME_BUF -- requirements
Module: uart_frame_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning UART byte width.
REQ-002 SHALL have parameter DEPTH, default 256, meaning buffer entries (power of two, >=4).
REQ-003 SHALL have derived localparam ADDR_W = clog2(DEPTH), meaning pointer width.
REQ-004 SHALL have port clk  in  1  system clock (50 MHz); single clock domain.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode  in  1  0 = store-then-replay, 1 = live echo.
REQ-007 SHALL have port key_flag  in  1  one-cycle debounced key event.
REQ-008 SHALL have port key_state  in  1  debounced key level; 0 = pressed.
REQ-009 SHALL have port rx_done  in  1  one-cycle pulse: rx_data valid.
REQ-010 SHALL have port rx_data  in  DATA_W  received byte.
REQ-011 SHALL have port tx_done  in  1  one-cycle pulse: sender finished byte.
REQ-012 SHALL have port send_en  out  1  one-cycle send request to sender.
REQ-013 SHALL have port tx_data  out  DATA_W  byte to send.
REQ-014 SHALL have port level  out  ADDR_W+1  entries currently stored.
REQ-015 SHALL have port busy  out  1  high while in any state other than IDLE.
REQ-016 SHALL have port overflow  out  1  sticky: byte dropped while full.

Function
REQ-017 SHALL store bytes in an internal DEPTH x DATA_W circular buffer with registered (1-cycle) read; wr_ptr/rd_ptr wrap modulo DEPTH.
REQ-018 SHALL write rx_data at wr_ptr and increment level on rx_done when level < DEPTH, in any state and either mode.
REQ-019 SHALL drop rx_data on rx_done when level == DEPTH, leaving pointers and level unchanged.
REQ-020 SHALL define key press as key_flag && !key_state; release events ignored.
REQ-021 SHALL use FSM IDLE -> FETCH -> LOAD -> WAIT_TX -> (FETCH | IDLE).
REQ-022 IDLE -> FETCH: mode 0 on key press with level > 0 (latches replay count = level); mode 1 whenever level > 0.
REQ-023 FETCH SHALL present rd_ptr to RAM; LOAD SHALL register RAM output to tx_data, pop (rd_ptr+1, level-1), and assert send_en for exactly that cycle.
REQ-024 tx_data SHALL hold stable from send_en until tx_done; at most one byte outstanding.
REQ-025 WAIT_TX on tx_done: mode 0 decrements replay count and goes FETCH if nonzero, else IDLE; mode 1 goes FETCH if level > 0, else IDLE.
REQ-026 Bytes received during a mode-0 replay SHALL be kept for the next replay, not sent.
REQ-027 Simultaneous write and pop in one cycle SHALL leave level unchanged, both pointers advance.
REQ-028 Key press while busy SHALL be ignored; mode SHALL be sampled only in IDLE.
REQ-029 Send latency: send_en SHALL assert 2 cycles after leaving IDLE.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, pointers 0, level 0, replay count 0, send_en 0, tx_data 0, busy 0, overflow 0; RAM contents undefined.
REQ-031 Reset mid-replay SHALL abandon buffer contents; an outstanding tx_done after reset SHALL be ignored.

Configuration
REQ-032 Macro UART_FRAME_BUF_OVF_EN defined: overflow sets on REQ-019 drop, clears on next mode-0 replay start or reset.
REQ-033 Macro undefined: overflow tied 0, drops remain silent.

Structure
REQ-034 Shared package uart_buf_pkg SHALL hold FSM state enum and MODE_REPLAY/MODE_ECHO constants.
REQ-035 RAM SHALL be one sub-module frame_buf_ram (simple dual-port, registered read).

Verification
REQ-036 Mode 0: receive 0x41,0x42,0x43, key press -> three send_en, tx_data 0x41,0x42,0x43 in order, level 3->0, busy low after third tx_done.
REQ-037 Mode 1: rx 0x55 -> send_en 2 cycles after IDLE exit with tx_data 0x55; level returns 0.
REQ-038 Fill DEPTH=4 with 1..4, rx 0x99 -> level stays 4, 0x99 never sent, overflow=1 (macro defined) / 0 (undefined).
REQ-039 Mode 0: replay 2 bytes, rx 0x77 during replay -> exactly 2 sent, level 1 after, second key press sends 0x77.
REQ-040 Assert rst_n low during WAIT_TX -> all outputs at reset values immediately; later tx_done produces no send_en.
REQ-041 Wrap: DEPTH=4, push/pop 10 bytes 0x00..0x09 -> sent in order, pointers wrap, level never exceeds 4.
